// File: rtl/cache_bus_pkg.sv
// Shared widths, state encoding and port identifiers for the cache/memory bus arbiter.
package cache_bus_pkg;

  localparam int unsigned LINE_BITS     = 512;
  localparam int unsigned BEAT_BITS     = 64;
  localparam int unsigned ADDR_BITS     = 64;
  // Beats per line; must stay a power of two so the beat counter wraps for free.
  localparam int unsigned BEATS         = LINE_BITS / BEAT_BITS;
  localparam int unsigned BEAT_IDX_BITS = $clog2(BEATS);

  localparam logic [ADDR_BITS-1:0] LINE_ADDR_MASK = 64'hffff_ffff_ffff_ffc0;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_DATA,
    WR_DATA,
    DONE
  } arb_state_t;

  typedef enum logic {
    PORT_IC = 1'b0,
    PORT_DC = 1'b1
  } port_id_t;

endpackage

// File: rtl/mem_line_buffer.sv
// One cache line plus its beat counter: parallel load, beat write at k, beat read at k.
module mem_line_buffer
  import cache_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [LINE_BITS-1:0] load_line,
  input  logic                 beat_wr,
  input  logic [BEAT_BITS-1:0] beat_wdata,
  input  logic                 beat_adv,
  output logic [LINE_BITS-1:0] line,
  output logic [BEAT_BITS-1:0] beat_rdata,
  output logic                 last_beat
);

  logic [BEAT_IDX_BITS-1:0] k;

  // The counter is never cleared on load: it wraps back to 0 after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= '0;
      k    <= '0;
    end else begin
      if (load) begin
        line <= load_line;
      end else if (beat_wr) begin
        line[k*BEAT_BITS +: BEAT_BITS] <= beat_wdata;
      end
      if (beat_wr || beat_adv) begin
        k <= k + 1'b1;
      end
    end
  end

  assign beat_rdata = line[k*BEAT_BITS +: BEAT_BITS];
  assign last_beat  = (k == BEAT_IDX_BITS'(BEATS - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one beat-wide memory bus between the icache and dcache.
module cache_mem_arbiter
  import cache_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ic_req,
  input  logic [ADDR_BITS-1:0] ic_addr,
  input  logic                 ic_wr,
  input  logic [LINE_BITS-1:0] ic_wdata,
  output logic [LINE_BITS-1:0] ic_rdata,
  output logic                 ic_valid,
  input  logic                 dc_req,
  input  logic [ADDR_BITS-1:0] dc_addr,
  input  logic                 dc_wr,
  input  logic [LINE_BITS-1:0] dc_wdata,
  output logic [LINE_BITS-1:0] dc_rdata,
  output logic                 dc_valid,
  output logic                 bus_req,
  output logic [ADDR_BITS-1:0] bus_addr,
  output logic                 bus_wr,
  output logic [BEAT_BITS-1:0] bus_wdata,
  input  logic                 bus_reqack,
  input  logic [BEAT_BITS-1:0] bus_resp,
  input  logic                 bus_respcyc,
  output logic                 bus_respack
);

  arb_state_t state, next_state;
  port_id_t   grant_q, rr_q, pick;
  logic [ADDR_BITS-1:0] addr_q;

  logic                 grant_en, beat_wr, beat_adv, last_beat;
  logic                 sel_wr;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [LINE_BITS-1:0] sel_wdata, line;

  // On a tie the port that was not served last wins.
  always_comb begin
    pick = PORT_IC;
    if (ic_req && dc_req) begin
      pick = (rr_q == PORT_IC) ? PORT_DC : PORT_IC;
    end else if (dc_req) begin
      pick = PORT_DC;
    end
  end

  assign sel_wr    = (pick == PORT_DC) ? dc_wr    : ic_wr;
  assign sel_addr  = (pick == PORT_DC) ? dc_addr  : ic_addr;
  assign sel_wdata = (pick == PORT_DC) ? dc_wdata : ic_wdata;

  always_comb begin
    next_state = state;
    grant_en   = 1'b0;
    beat_wr    = 1'b0;
    beat_adv   = 1'b0;
    case (state)
      IDLE: begin
        if (ic_req || dc_req) begin
          grant_en   = 1'b1;
          next_state = sel_wr ? WR_DATA : RD_CMD;
        end
      end
      RD_CMD: begin
        if (bus_reqack) next_state = RD_DATA;
      end
      RD_DATA: begin
        if (bus_respcyc) begin
          beat_wr = 1'b1;
          if (last_beat) next_state = DONE;
        end
      end
      WR_DATA: begin
        if (bus_reqack) begin
          beat_adv = 1'b1;
          if (last_beat) next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= PORT_IC;
      rr_q    <= PORT_DC;
      addr_q  <= '0;
    end else begin
      state <= next_state;
      if (grant_en) begin
        grant_q <= pick;
        rr_q    <= pick;
        addr_q  <= sel_addr & LINE_ADDR_MASK;
      end
    end
  end

  mem_line_buffer u_line (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (grant_en),
    .load_line  (sel_wdata),
    .beat_wr    (beat_wr),
    .beat_wdata (bus_resp),
    .beat_adv   (beat_adv),
    .line       (line),
    .beat_rdata (bus_wdata),
    .last_beat  (last_beat)
  );

  assign bus_req     = (state == RD_CMD) || (state == WR_DATA);
  assign bus_wr      = (state == WR_DATA);
  assign bus_addr    = addr_q;
  assign bus_respack = (state == RD_DATA) && bus_respcyc;

  assign ic_valid = (state == DONE) && (grant_q == PORT_IC);
  assign dc_valid = (state == DONE) && (grant_q == PORT_DC);
  assign ic_rdata = line;
  assign dc_rdata = line;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomised bench: bus slave, requesters and a transaction-level reference model in one process.
module tb_cache_mem_arbiter;
  import cache_bus_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ic_req, ic_wr, dc_req, dc_wr;
  logic [ADDR_BITS-1:0] ic_addr, dc_addr, bus_addr;
  logic [LINE_BITS-1:0] ic_wdata, dc_wdata, ic_rdata, dc_rdata;
  logic                 ic_valid, dc_valid;
  logic                 bus_req, bus_wr, bus_reqack, bus_respcyc, bus_respack;
  logic [BEAT_BITS-1:0] bus_wdata, bus_resp;

  cache_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_wr(ic_wr), .ic_wdata(ic_wdata),
    .ic_rdata(ic_rdata), .ic_valid(ic_valid),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_wr(dc_wr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_valid(dc_valid),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_reqack(bus_reqack), .bus_resp(bus_resp), .bus_respcyc(bus_respcyc),
    .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                 port;
    logic                 wr;
    logic [ADDR_BITS-1:0] addr;
    logic [LINE_BITS-1:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic        served[$];
  int unsigned n_chk = 0, n_bad = 0;
  int unsigned cyc = 0, req_cyc = 0, valid_cyc = 0;
  int unsigned rd_beats, wr_beats, pat_idx, stall_n, a3_cycles;
  int unsigned ack_mode = 0, resp_mode = 0;
  logic        started, cmd_done, plain = 1'b0, last_served = 1'b1;
  logic [0:9]  pat = 10'b1011001111;

  task automatic check_val(input string tag, input logic [LINE_BITS-1:0] got,
                           input logic [LINE_BITS-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rd_beat(input logic [63:0] a, input int unsigned k);
    if (plain) return 64'(k);
    return (a ^ 64'h5A5A_0000_C3C3_0000) + 64'(k) * 64'h0101_0101_0101_0101;
  endfunction

  function automatic logic [LINE_BITS-1:0] line_of(input logic [63:0] a);
    logic [LINE_BITS-1:0] l;
    for (int unsigned k = 0; k < BEATS; k++) l[k*64 +: 64] = rd_beat(a, k);
    return l;
  endfunction

  function automatic logic [LINE_BITS-1:0] rnd_line();
    logic [LINE_BITS-1:0] l;
    for (int unsigned k = 0; k < LINE_BITS/32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic clr_txn();
    started = 1'b0; cmd_done = 1'b0;
    rd_beats = 0; wr_beats = 0; pat_idx = 0; stall_n = 0;
  endtask

  // One clock: drive the bus slave at the falling edge, then score what the next rising edge will see.
  task automatic tick();
    txn_t cur;
    @(negedge clk);
    if (rst_n) begin
      case (ack_mode)
        0: bus_reqack = 1'b1;
        1: bus_reqack = bus_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
        default: begin
          bus_reqack = 1'b1;
          if (bus_req && bus_wr && wr_beats == 3 && stall_n < 2) begin
            bus_reqack = 1'b0;
            stall_n++;
          end
        end
      endcase
      case (resp_mode)
        0: bus_respcyc = 1'b1;
        1: bus_respcyc = ($urandom_range(0, 9) < 6);
        default: begin
          if (exp_q.size() != 0 && cmd_done && rd_beats < 8) begin
            bus_respcyc = (pat_idx < 10) ? pat[pat_idx] : 1'b1;
            pat_idx++;
          end else begin
            bus_respcyc = 1'b1;
          end
        end
      endcase
      bus_resp = (exp_q.size() != 0) ? rd_beat(exp_q[0].addr & LINE_ADDR_MASK, rd_beats)
                                     : {$urandom, $urandom};
    end
    #1;
    if (rst_n) begin
      if (bus_respack) check_val("respack_without_respcyc", bus_respcyc, 1'b1);
      if (exp_q.size() == 0) begin
        if (bus_respcyc) check_val("stray_respack", bus_respack, 1'b0);
        check_val("idle_bus_req", bus_req, 1'b0);
        check_val("idle_valid", {ic_valid, dc_valid}, 2'b00);
      end else begin
        cur = exp_q[0];
        if (bus_req) begin
          check_val("bus_wr", bus_wr, cur.wr);
          check_val("bus_addr", bus_addr, cur.addr & LINE_ADDR_MASK);
          check_val("respack_in_cmd", bus_respack, 1'b0);
          if (!started) begin
            started = 1'b1;
            if (cur.port) begin dc_addr = {$urandom, $urandom}; dc_wdata = rnd_line(); end
            else          begin ic_addr = {$urandom, $urandom}; ic_wdata = rnd_line(); end
          end
          if (cur.wr && bus_wdata == 64'hA3) a3_cycles++;
          if (bus_reqack) begin
            if (cur.wr) begin
              check_val("wdata_beat", bus_wdata, (wr_beats < 8) ? cur.wdata[wr_beats*64 +: 64] : 'x);
              wr_beats++;
            end else begin
              cmd_done = 1'b1;
            end
          end
        end
        if (bus_respcyc && bus_respack) begin
          check_val("beat_in_read_phase", {cur.wr, cmd_done}, 2'b01);
          rd_beats++;
        end
        if (ic_valid || dc_valid) begin
          check_val("valid_port", {ic_valid, dc_valid}, cur.port ? 2'b01 : 2'b10);
          check_val("beat_count", cur.wr ? wr_beats : rd_beats, 8);
          if (!cur.wr)
            check_val("rdata", cur.port ? dc_rdata : ic_rdata, line_of(cur.addr & LINE_ADDR_MASK));
          valid_cyc = cyc;
          if (cur.port) dc_req = 1'b0; else ic_req = 1'b0;
          served.push_back(cur.port);
          void'(exp_q.pop_front());
          clr_txn();
        end
      end
    end
    cyc++;
  endtask

  task automatic start_round(input logic ui, input logic ud, input logic iw, input logic dw,
                             input logic [63:0] ia, input logic [63:0] da,
                             input logic [LINE_BITS-1:0] iwd, input logic [LINE_BITS-1:0] dwd);
    txn_t ti, td;
    ti = '{port: 1'b0, wr: iw, addr: ia, wdata: iwd};
    td = '{port: 1'b1, wr: dw, addr: da, wdata: dwd};
    if (ui) begin ic_addr = ia; ic_wr = iw; ic_wdata = iwd; ic_req = 1'b1; end
    if (ud) begin dc_addr = da; dc_wr = dw; dc_wdata = dwd; dc_req = 1'b1; end
    if (ui && ud) begin
      if (last_served) begin exp_q.push_back(ti); exp_q.push_back(td); last_served = 1'b1; end
      else             begin exp_q.push_back(td); exp_q.push_back(ti); last_served = 1'b0; end
    end else if (ui) begin
      exp_q.push_back(ti); last_served = 1'b0;
    end else begin
      exp_q.push_back(td); last_served = 1'b1;
    end
    req_cyc = cyc;
  endtask

  task automatic wait_done();
    for (int unsigned i = 0; i < 3000 && exp_q.size() != 0; i++) tick();
    check_val("drain", exp_q.size(), 0);
    if (exp_q.size() != 0) begin
      exp_q.delete(); ic_req = 1'b0; dc_req = 1'b0; clr_txn();
    end
    tick();
  endtask

  task automatic chk_zero(input string tag);
    check_val({tag, "_ctrl"}, {bus_req, bus_wr, bus_respack, ic_valid, dc_valid}, 5'b0);
    check_val({tag, "_addr"}, bus_addr, 0);
    check_val({tag, "_wdata"}, bus_wdata, 0);
    check_val({tag, "_ic_rdata"}, ic_rdata, 0);
    check_val({tag, "_dc_rdata"}, dc_rdata, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_zero("reset");
    exp_q.delete(); clr_txn();
    ic_req = 1'b0; dc_req = 1'b0; last_served = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [LINE_BITS-1:0] wl;
    logic [3:0]           ord;
    rst_n = 1'b0;
    ic_req = 0; ic_wr = 0; ic_addr = '0; ic_wdata = '0;
    dc_req = 0; dc_wr = 0; dc_addr = '0; dc_wdata = '0;
    bus_reqack = 0; bus_resp = '0; bus_respcyc = 0;
    clr_txn();
    repeat (3) @(negedge clk);
    chk_zero("por");
    rst_n = 1'b1;
    tick();

    // Single zero-wait dcache fill with beat k = k.
    plain = 1'b1;
    start_round(0, 1, 0, 0, '0, 64'h1234_5678, '0, '0);
    wait_done();
    check_val("rd_latency", valid_cyc - req_cyc + 1, 10);
    plain = 1'b0;

    // icache write-back with two withheld acks on beat 3.
    for (int unsigned k = 0; k < BEATS; k++) wl[k*64 +: 64] = 64'hA0 + 64'(k);
    ack_mode = 2; a3_cycles = 0;
    start_round(1, 0, 1, 0, 64'h8000_1077, '0, wl, '0);
    wait_done();
    check_val("a3_hold_cycles", a3_cycles, 3);
    check_val("wr_latency", valid_cyc - req_cyc + 1, 11);
    ack_mode = 0;

    // Tie right after reset: icache first.
    do_reset();
    tick();
    served.delete();
    start_round(1, 1, 0, 0, {$urandom, $urandom}, {$urandom, $urandom}, '0, '0);
    wait_done();
    check_val("tie_count", served.size(), 2);
    if (served.size() == 2) check_val("tie_order", {served[0], served[1]}, 2'b01);

    // Repeated contention alternates ic, dc, ic, dc.
    served.delete();
    repeat (2) begin
      start_round(1, 1, 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  rnd_line(), rnd_line());
      wait_done();
    end
    check_val("contend_count", served.size(), 4);
    if (served.size() == 4) begin
      ord = {served[0], served[1], served[2], served[3]};
      check_val("contend_order", ord, 4'b0101);
    end

    // Gapped responses, with stray respcyc before and after.
    resp_mode = 2;
    repeat (3) tick();
    start_round(0, 1, 0, 0, '0, {$urandom, $urandom}, '0, '0);
    wait_done();
    repeat (4) tick();

    // Random traffic.
    ack_mode = 1; resp_mode = 1;
    for (int unsigned r = 0; r < 40; r++) begin
      logic ui, ud;
      ui = 1'($urandom); ud = 1'($urandom);
      if (!ui && !ud) ud = 1'b1;
      start_round(ui, ud, 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  rnd_line(), rnd_line());
      wait_done();
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset in the middle of a fill, then a clean fill.
    start_round(0, 1, 0, 0, '0, {$urandom, $urandom}, '0, '0);
    for (int unsigned i = 0; i < 300 && rd_beats < 4; i++) tick();
    check_val("reached_beat4", rd_beats, 4);
    do_reset();
    ack_mode = 0; resp_mode = 0;
    tick();
    start_round(0, 1, 0, 0, '0, 64'hDEAD_BEEF_0000_1234, '0, '0);
    wait_done();
    check_val("post_reset_latency", valid_cyc - req_cyc + 1, 10);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

endmodule
